// File: rtl/add7_sched_pkg.sv
// Shared types and constants for the add7 job scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package add7_sched_pkg;

    localparam int NARGS = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Index width that stays legal (>= 1 bit) for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add7_sched_if.sv
// Bundle of requester, response and kernel signals for add7_sched.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready and resp_valid/resp_ready handshakes.
// slave modport = scheduler side, master modport = environment side.
interface add7_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 64
);
    import add7_sched_pkg::*;

    localparam int IW = idx_w(NREQ);

    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*NARGS*W-1:0] req_args;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [IW-1:0]           resp_id;
    logic [W-1:0]            resp_data;
    logic                    resp_err;
    logic                    k_r_enable;
    logic [NARGS*W-1:0]      k_args;
    logic                    k_w_enable;
    logic [W-1:0]            k_result;

    modport slave (
        input  req_valid, req_args, resp_ready, k_w_enable, k_result,
        output req_ready, resp_valid, resp_id, resp_data, resp_err, k_r_enable, k_args
    );

    modport master (
        output req_valid, req_args, resp_ready, k_w_enable, k_result,
        input  req_ready, resp_valid, resp_id, resp_data, resp_err, k_r_enable, k_args
    );

endinterface

// File: rtl/add7_sched_rr_arbiter.sv
// Round-robin one-hot picker: first asserted request at or after ptr.
// Latency: purely combinational.
// Backpressure: none; gnt is zero when req is zero.
// Ports: req (N requests), ptr (search start, must be < N), gnt (one-hot).
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    logic [N-1:0] req_lo;
    logic [N-1:0] pick;

    always_comb begin
        // Rotate so ptr lands on bit 0, isolate the lowest set bit,
        // then rotate back (right by N-ptr equals left by ptr).
        req_lo = N'({req, req} >> ptr);
        pick   = req_lo & (~req_lo + 1'b1);
        gnt    = N'({pick, pick} >> (N - int'(ptr)));
    end

endmodule

// File: rtl/add7_sched.sv
// Shares one add7 kernel among NREQ requesters: grant, launch, wait, respond.
// Latency: 4 cycles minimum grant-to-response-accept with a 1-cycle kernel.
// Backpressure: resp_ready low holds RESP; no new grant until it is accepted.
// Ports: clk, rst_n (sync, active-low), io (add7_sched_if.slave).
// Optional macro ADD7_SCHED_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT cycles
// that produces an error response (resp_err=1, resp_data=0).
module add7_sched
    import add7_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    add7_sched_if.slave    io
);
    localparam int IW = idx_w(NREQ);
    localparam int AW = NARGS * W;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IW-1:0]   resp_id_q, resp_id_d;
    logic [AW-1:0]   k_args_q, k_args_d;
    logic [W-1:0]    resp_data_q, resp_data_d;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic [AW-1:0]   sel_args;

`ifdef ADD7_SCHED_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           resp_err_q, resp_err_d;
    logic           wdog_exp;
    assign wdog_exp = (wdog_q == WDW'(TIMEOUT - 1));
`endif

    rr_arbiter #(.N(NREQ), .PW(IW)) u_arb (
        .req (io.req_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt)
    );

    // gnt is one-hot, so OR-ing is a mux.
    always_comb begin
        gnt_idx  = '0;
        sel_args = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_idx  = gnt_idx | IW'(i);
                sel_args = sel_args | io.req_args[i*AW +: AW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_idx_d   = gnt_idx_q;
        resp_id_d   = resp_id_q;
        k_args_d    = k_args_q;
        resp_data_d = resp_data_q;
`ifdef ADD7_SCHED_TIMEOUT_EN
        wdog_d      = wdog_q;
        resp_err_d  = resp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (|io.req_valid) begin
                    state_d   = LAUNCH;
                    gnt_idx_d = gnt_idx;
                    k_args_d  = sel_args;
                    rr_ptr_d  = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
            LAUNCH: begin
                // Any done seen alongside the start pulse is deliberately dropped.
                state_d = WAIT;
`ifdef ADD7_SCHED_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            WAIT: begin
                if (io.k_w_enable) begin
                    state_d     = RESP;
                    resp_data_d = io.k_result;
                    resp_id_d   = gnt_idx_q;
`ifdef ADD7_SCHED_TIMEOUT_EN
                    resp_err_d  = 1'b0;
                end else if (wdog_exp) begin
                    state_d     = RESP;
                    resp_data_d = '0;
                    resp_id_d   = gnt_idx_q;
                    resp_err_d  = 1'b1;
                end else begin
                    wdog_d      = wdog_q + 1'b1;
`endif
                end
            end
            RESP: begin
                if (io.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_idx_q   <= '0;
            resp_id_q   <= '0;
            k_args_q    <= '0;
            resp_data_q <= '0;
`ifdef ADD7_SCHED_TIMEOUT_EN
            wdog_q      <= '0;
            resp_err_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            resp_id_q   <= resp_id_d;
            k_args_q    <= k_args_d;
            resp_data_q <= resp_data_d;
`ifdef ADD7_SCHED_TIMEOUT_EN
            wdog_q      <= wdog_d;
            resp_err_q  <= resp_err_d;
`endif
        end
    end

    // Gating with rst_n keeps handshake outputs quiet while reset is held,
    // including before the first reset edge has cleared state_q.
    assign io.req_ready  = (rst_n && state_q == IDLE) ? gnt : '0;
    assign io.k_r_enable = rst_n && (state_q == LAUNCH);
    assign io.resp_valid = rst_n && (state_q == RESP);
    assign io.k_args     = k_args_q;
    assign io.resp_data  = resp_data_q;
    assign io.resp_id    = resp_id_q;
`ifdef ADD7_SCHED_TIMEOUT_EN
    assign io.resp_err   = resp_err_q;
`else
    assign io.resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_add7_sched.sv
// Bench for add7_sched: kernel model, scoreboard of expected responses.
// Latency: n/a.
// Backpressure: exercised by holding resp_ready low.
module tb_add7_sched;
    import add7_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 64;
    localparam int TO   = 16;
    localparam int AW   = NARGS * W;

    typedef struct {
        logic [1:0]   id;
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    add7_sched_if #(.NREQ(NREQ), .W(W)) io ();

    add7_sched #(.NREQ(NREQ), .W(W), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    int           kre_cnt = 0;
    int           kre_cyc = 0;
    int           resp_cyc = 0;
    int           gnt_log[$];
    int           gnt_cyc[$];
    exp_t         sb[$];
    exp_t         e_mon;
    bit           exp_to = 1'b0;
    logic [1:0]   last_id;
    logic [W-1:0] last_data;
    logic [AW-1:0] args [NREQ];

    int           klat   = 1;
    bit           k_tie  = 1'b0;
    bit           k_dead = 1'b0;
    int           kcnt   = 0;
    logic [W-1:0] kres;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] sum7(input logic [AW-1:0] a);
        logic [W-1:0] s;
        s = '0;
        for (int j = 0; j < NARGS; j++) s = s + a[j*W +: W];
        return s;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: grants push expectations, accepted responses pop and compare.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                if (io.req_ready[i]) begin
                    chk("gnt_needs_valid", 64'(io.req_valid[i]), 64'd1);
                    gnt_log.push_back(i);
                    gnt_cyc.push_back(cyc);
                    e_mon.id   = 2'(i);
                    e_mon.data = exp_to ? '0 : sum7(args[i]);
                    e_mon.err  = exp_to;
                    sb.push_back(e_mon);
                end
            end
            if (io.k_r_enable) begin
                kre_cnt++;
                kre_cyc = cyc;
            end
            if (io.resp_valid && io.resp_ready) begin
                resp_cyc  = cyc;
                last_id   = io.resp_id;
                last_data = io.resp_data;
                if (sb.size() == 0) begin
                    chk("resp_unexpected", 64'd1, 64'd0);
                end else begin
                    e_mon = sb.pop_front();
                    chk("resp_id", 64'(io.resp_id), 64'(e_mon.id));
                    chk("resp_data", io.resp_data, e_mon.data);
                    chk("resp_err", 64'(io.resp_err), 64'(e_mon.err));
                end
            end
        end
    end

    // Kernel model: done klat cycles after the launch cycle, sum of operands.
    initial begin
        io.k_w_enable = 1'b0;
        io.k_result   = '0;
        forever begin
            @(posedge clk);
            #1;
            io.k_w_enable = 1'b0;
            if (kcnt > 0) begin
                kcnt--;
                if (kcnt == 0 && !k_dead) begin
                    io.k_w_enable = 1'b1;
                    io.k_result   = kres;
                end
            end
            if (k_tie) begin
                io.k_w_enable = 1'b1;
                io.k_result   = sum7(io.k_args);
            end
            if (io.k_r_enable && !k_tie) begin
                kcnt = klat;
                kres = sum7(io.k_args);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic wait_grant(input int i, input string tag);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            #1;
            if (io.req_ready[i]) break;
            n++;
            if (n > 60) begin
                chk({tag, "_no_grant"}, 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 200) begin
                chk({tag, "_drain"}, 64'(sb.size()), 64'd0);
                sb.delete();
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0[NARGS] = '{123, 234, 345, 456, 567, 678, 789};
        int kre0;
        int seen;
        int n;
        int exp_gnt[5] = '{0, 1, 2, 3, 0};
        logic [1:0]   cap_id;
        logic [W-1:0] cap_data;
        logic         cap_err;
        int           exp_kre;

        for (int j = 0; j < NARGS; j++) args[0][j*W +: W] = W'(a0[j]);
        for (int i = 1; i < NREQ; i++)
            for (int j = 0; j < NARGS; j++) args[i][j*W +: W] = W'($urandom());
        for (int i = 0; i < NREQ; i++) io.req_args[i*AW +: AW] = args[i];
        io.resp_ready = 1'b1;
        io.req_valid  = '1;
        exp_kre = 0;

        // Reset values, with all requesters already valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(io.req_ready), 64'd0);
        chk("rst_resp_valid", 64'(io.resp_valid), 64'd0);
        chk("rst_k_r_enable", 64'(io.k_r_enable), 64'd0);
        chk("rst_resp_id", 64'(io.resp_id), 64'd0);
        chk("rst_resp_data", io.resp_data, 64'd0);
        chk("rst_resp_err", 64'(io.resp_err), 64'd0);
        chk("rst_k_args_zero", 64'(io.k_args == '0), 64'd1);

        // Contention from reset: 0,1,2,3,0 and 4-cycle grant spacing.
        @(posedge clk);
        #1 rst_n = 1'b1;
        klat = 1;
        n = 0;
        while (gnt_log.size() < 5 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1 io.req_valid = '0;
        chk("cont_grants", 64'(gnt_log.size()), 64'd5);
        for (int k = 0; k < 5 && k < gnt_log.size(); k++)
            chk("cont_order", 64'(gnt_log[k]), 64'(exp_gnt[k]));
        if (gnt_cyc.size() >= 2)
            chk("cont_spacing", 64'(gnt_cyc[1] - gnt_cyc[0]), 64'd4);
        drain("cont");
        chk("cont_kre", 64'(kre_cnt), 64'd5);
        exp_kre = 5;

        // Single job from requester 0 with a 3-cycle kernel.
        klat = 3;
        kre0 = kre_cnt;
        io.req_valid = 4'b0001;
        wait_grant(0, "single");
        io.req_valid = '0;
        drain("single");
        chk("single_kre", 64'(kre_cnt - kre0), 64'd1);
        chk("single_id", 64'(last_id), 64'd0);
        chk("single_data", last_data, 64'd3192);
        exp_kre += 1;

        // Backpressure: pointer is 1, so 2 wins over 0; hold the response.
        klat = 2;
        io.resp_ready = 1'b0;
        io.req_valid  = 4'b0101;
        wait_grant(2, "bp");
        io.req_valid = 4'b0001;
        n = 0;
        while (!io.resp_valid && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("bp_resp_seen", 64'(io.resp_valid), 64'd1);
        cap_id   = io.resp_id;
        cap_data = io.resp_data;
        cap_err  = io.resp_err;
        chk("bp_cap_data", cap_data, sum7(args[2]));
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid_held", 64'(io.resp_valid), 64'd1);
            chk("bp_id_held", 64'(io.resp_id), 64'(cap_id));
            chk("bp_data_held", io.resp_data, cap_data);
            chk("bp_err_held", 64'(io.resp_err), 64'(cap_err));
            chk("bp_no_grant", 64'(io.req_ready), 64'd0);
        end
        @(posedge clk);
        #1 io.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_next_grant", 64'(io.req_ready), 64'b0001);
        @(posedge clk);
        #1 io.req_valid = '0;
        drain("bp");
        exp_kre += 2;

        // Reset during WAIT: job dropped, late done ignored, pointer back to 0.
        klat = 6;
        io.req_valid = 4'b0010;
        wait_grant(1, "rst");
        io.req_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        exp_kre += 1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (io.resp_valid) seen++;
        end
        chk("rst_no_resp", 64'(seen), 64'd0);
        klat = 1;
        @(posedge clk);
        #1 io.req_valid = '1;
        @(negedge clk);
        chk("rst_ptr_zero", 64'(io.req_ready), 64'b0001);
        @(posedge clk);
        #1 io.req_valid = '0;
        drain("rst");
        exp_kre += 1;

        // Done tied high: ignored in LAUNCH, completes on first WAIT cycle.
        k_tie = 1'b1;
        io.req_valid = 4'b1000;
        wait_grant(3, "tie");
        io.req_valid = '0;
        drain("tie");
        chk("tie_turnaround", 64'(resp_cyc - gnt_cyc[gnt_cyc.size()-1]), 64'd3);
        chk("tie_id", 64'(last_id), 64'd3);
        k_tie = 1'b0;
        exp_kre += 1;
        @(posedge clk);
        #1;

`ifdef ADD7_SCHED_TIMEOUT_EN
        // Kernel never finishes: error response TO cycles after WAIT entry.
        k_dead = 1'b1;
        exp_to = 1'b1;
        io.req_valid = 4'b0100;
        wait_grant(2, "to");
        io.req_valid = '0;
        drain("to");
        chk("to_latency", 64'(resp_cyc - kre_cyc), 64'(TO + 1));
        chk("to_err", 64'(io.resp_err), 64'd1);
        exp_to = 1'b0;
        k_dead = 1'b0;
        exp_kre += 1;
`endif

        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("kre_total", 64'(kre_cnt), 64'(exp_kre));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/add7_sched.md
ADD7_SCHED -- requirements
Module: add7_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one add7 kernel instance.
REQ-002 Parameter W, default 64: operand and result width.
REQ-003 Parameter TIMEOUT, default 1024: watchdog limit in cycles, used only when ADD7_SCHED_TIMEOUT_EN is defined.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst_n  in  1  reset; synchronous and active-low.
REQ-006 req_valid  in  NREQ  per-requester job request.
REQ-007 req_ready  out  NREQ  one-hot grant; job accepted in the cycle req_valid[i]&req_ready[i].
REQ-008 req_args  in  NREQ*7*W  seven operands per requester; requester i in slice i, operand j at [(i*7+j)*W +: W].
REQ-009 resp_valid  out  1  completed result available.
REQ-010 resp_ready  in  1  consumer accepts response.
REQ-011 resp_id  out  $clog2(NREQ)  requester index of the response.
REQ-012 resp_data  out  W  kernel result.
REQ-013 resp_err  out  1  response is a timeout error (always 0 without the macro).
REQ-014 k_r_enable  out  1  kernel start pulse.
REQ-015 k_args  out  7*W  operands to the kernel, operand j at [j*W +: W].
REQ-016 k_w_enable  in  1  kernel done.
REQ-017 k_result  in  W  kernel result, valid when k_w_enable is high.

Function
REQ-018 FSM states: IDLE, LAUNCH, WAIT, RESP.
REQ-019 IDLE: when any req_valid is high, grant exactly one requester by round-robin starting at rr_ptr, assert req_ready for it for one cycle, latch its operands into k_args, and go to LAUNCH.
REQ-020 req_ready is combinational from state==IDLE, req_valid and rr_ptr; it is never asserted outside IDLE.
REQ-021 LAUNCH: k_r_enable=1 for exactly one cycle; next state is WAIT.
REQ-022 k_args holds stable from LAUNCH until the cycle the FSM leaves RESP.
REQ-023 WAIT: on the first cycle k_w_enable=1, capture k_result into resp_data, set resp_id to the granted index and resp_err to 0, then go to RESP.
REQ-024 k_w_enable is ignored in IDLE, LAUNCH and RESP; a done asserted in the same cycle as k_r_enable does not complete the job.
REQ-025 RESP: resp_valid=1 with resp_id, resp_data and resp_err held stable until resp_ready=1; then return to IDLE.
REQ-026 resp_valid&resp_ready in RESP completes the response in that cycle; the earliest next grant is the following cycle.
REQ-027 rr_ptr advances to (granted+1) mod NREQ at grant and wraps from NREQ-1 to 0.
REQ-028 A requester that deasserts req_valid before its grant is skipped with no side effects.
REQ-029 Minimum job turnaround is 4 cycles (grant, launch, done, response) when the kernel has 1-cycle latency and resp_ready is held high.
REQ-030 The block adds no arithmetic; resp_data equals k_result bit-exact.

Reset
REQ-031 When rst_n=0 at a posedge: state=IDLE, rr_ptr=0, k_args=0, resp_data=0, resp_id=0, resp_err=0, watchdog=0.
REQ-032 Under reset, k_r_enable, resp_valid and req_ready are all 0.
REQ-033 A reset in any state abandons the job in flight without issuing a response; a late k_w_enable after reset is ignored.

Configuration
REQ-034 The macro ADD7_SCHED_TIMEOUT_EN compiles in a watchdog counter.
REQ-035 With ADD7_SCHED_TIMEOUT_EN defined, the watchdog clears on entering WAIT and counts WAIT cycles.
REQ-036 With the macro, if TIMEOUT cycles elapse without k_w_enable, the FSM goes to RESP with resp_err=1 and resp_data=0.
REQ-037 With the macro, if done and timeout occur in the same cycle, done wins.
REQ-038 Without ADD7_SCHED_TIMEOUT_EN, no counter exists, resp_err is tied to 0, and WAIT waits indefinitely.

Structure
REQ-039 Package add7_sched_pkg holds NARGS=7, the state enum type, and the index-width helper.
REQ-040 One sub-module, rr_arbiter (NREQ-wide request vector plus pointer in, one-hot grant out, purely combinational), is instantiated once.

Verification
REQ-041 Single job: requester 0 args 123,234,345,456,567,678,789, with a model kernel of 3-cycle latency -> one k_r_enable pulse, then resp_valid with resp_id=0 and resp_data=3192.
REQ-042 Contention: all 4 requesters valid from reset -> grants in order 0,1,2,3,0, with one k_r_enable per job.
REQ-043 Backpressure: resp_ready held low 10 cycles -> resp_* stable, no new req_ready, and the grant follows the accepting cycle.
REQ-044 Reset mid-WAIT: rst_n low 1 cycle during WAIT, then kernel done -> no resp_valid, state IDLE, rr_ptr=0.
REQ-045 Timeout (macro on, TIMEOUT=16): kernel never done -> resp_valid at WAIT+16 with resp_err=1 and resp_data=0.
REQ-046 Same-cycle done: k_w_enable tied high -> it is ignored during LAUNCH and completes on the first WAIT cycle.
